// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes and
// the per-icode register-ID decode used by the decode stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'd4;

  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SHLT = 4'd2;
  localparam logic [3:0] SADR = 4'd3;
  localparam logic [3:0] SINS = 4'd4;

  // Register IDs an instruction reads and writes
  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_t;

  function automatic dec_t decode_regs(input logic [3:0] icode,
                                       input logic [3:0] ra,
                                       input logic [3:0] rb);
    dec_t d;
    d = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      IRRMOVQ: begin d.src_a = ra;   d.dst_e = rb; end
      IIRMOVQ: begin d.dst_e = rb; end
      IRMMOVQ: begin d.src_a = ra;   d.src_b = rb; end
      IMRMOVQ: begin d.src_b = rb;   d.dst_m = ra; end
      IOPQ:    begin d.src_a = ra;   d.src_b = rb;   d.dst_e = rb; end
      ICALL:   begin d.src_b = RRSP; d.dst_e = RRSP; end
      IRET:    begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; end
      IPUSHQ:  begin d.src_a = ra;   d.src_b = RRSP; d.dst_e = RRSP; end
      IPOPQ:   begin d.src_a = RRSP; d.src_b = RRSP; d.dst_e = RRSP; d.dst_m = ra; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipe_decode_unit_if.sv
// Decode-stage bus: fetch outputs, later-stage forwarding/hazard inputs,
// decoded operands, pipeline controls and the register-file debug peek.
// master = surrounding pipeline (drives f_*/E_*/M_*/W_*/e_*), slave = decode unit.
interface pipe_decode_unit_if #(parameter int unsigned XLEN = 64) ();
  logic [3:0]      f_icode, f_ifun, f_rA, f_rB, f_stat;
  logic [XLEN-1:0] f_valC, f_valP;
  logic [3:0]      E_icode, E_dstM, M_icode;
  logic            e_Cnd;
  logic [3:0]      e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [XLEN-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]      d_icode, d_ifun, d_stat;
  logic [3:0]      d_srcA, d_srcB, d_dstE, d_dstM;
  logic [XLEN-1:0] d_valC, d_valA, d_valB;
  logic            F_stall, D_stall, D_bubble, E_bubble;
  logic [3:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output f_icode, f_ifun, f_rA, f_rB, f_stat, f_valC, f_valP,
           E_icode, E_dstM, M_icode, e_Cnd,
           e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
           e_valE, M_valE, m_valM, W_valE, W_valM, dbg_addr,
    input  d_icode, d_ifun, d_stat, d_srcA, d_srcB, d_dstE, d_dstM,
           d_valC, d_valA, d_valB, F_stall, D_stall, D_bubble, E_bubble, dbg_data
  );

  modport slave (
    input  f_icode, f_ifun, f_rA, f_rB, f_stat, f_valC, f_valP,
           E_icode, E_dstM, M_icode, e_Cnd,
           e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
           e_valE, M_valE, m_valM, W_valE, W_valM, dbg_addr,
    output d_icode, d_ifun, d_stat, d_srcA, d_srcB, d_dstE, d_dstM,
           d_valC, d_valA, d_valB, F_stall, D_stall, D_bubble, E_bubble, dbg_data
  );
endinterface

// File: rtl/y86_regfile.sv
// Y86-64 register file: two read ports, two write ports (M wins over E on the
// same index), a debug read port. IDs >= NREG (including RNONE) read as 0 and
// are never written.
//   clk, rst            : clock, synchronous active-high clear of all registers
//   rd_a/b_addr, _data  : combinational operand reads
//   wr_e/m_addr, _data  : writes on the rising edge
//   dbg_addr, dbg_data  : combinational peek
module y86_regfile #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      rd_a_addr,
  input  logic [3:0]      rd_b_addr,
  output logic [XLEN-1:0] rd_a_data,
  output logic [XLEN-1:0] rd_b_data,
  input  logic [3:0]      wr_e_addr,
  input  logic [XLEN-1:0] wr_e_data,
  input  logic [3:0]      wr_m_addr,
  input  logic [XLEN-1:0] wr_m_data,
  input  logic [3:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  import y86_pkg::*;

  localparam logic [3:0] NREG_L = 4'(NREG);

  logic [XLEN-1:0] regs [16];

  // Entries at or above NREG stay at their reset value of 0
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 16; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (i < NREG && 4'(i) != RNONE) begin
        if (wr_m_addr == 4'(i))      regs[i] <= wr_m_data;
        else if (wr_e_addr == 4'(i)) regs[i] <= wr_e_data;
      end
    end
  end

  assign rd_a_data = (rd_a_addr < NREG_L) ? regs[rd_a_addr] : '0;
  assign rd_b_data = (rd_b_addr < NREG_L) ? regs[rd_b_addr] : '0;
  assign dbg_data  = (dbg_addr  < NREG_L) ? regs[dbg_addr]  : '0;

endmodule

// File: rtl/pipe_decode_unit.sv
// Y86-64 decode stage: D pipeline register, register file, operand
// forwarding (FWD_EN=1) or RAW interlock (FWD_EN=0), and pipe stall/bubble control.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch inputs, later-stage hazard/forwarding inputs, decoded
//              outputs (combinational from D register), controls, debug peek
module pipe_decode_unit
  import y86_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 15,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_decode_unit_if.slave  bus
);

  logic [3:0]      dr_icode, dr_ifun, dr_ra, dr_rb, dr_stat;
  logic [XLEN-1:0] dr_valc, dr_valp;
  dec_t            dec;
  logic [XLEN-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic [3:0]      fw_dst [5];
  logic [XLEN-1:0] fw_val [5];
  logic [3:0]      ilk_dst [6];
  logic            lu, ret_h, mis, ilk, dep, d_stall, d_bubble;

  // D register: a bubble is a NOP with AOK status and no register IDs
  always_ff @(posedge clk) begin
    if (rst || (d_bubble && !d_stall)) begin
      dr_icode <= INOP;
      dr_ifun  <= 4'd0;
      dr_ra    <= RNONE;
      dr_rb    <= RNONE;
      dr_stat  <= SAOK;
      dr_valc  <= '0;
      dr_valp  <= '0;
    end else if (!d_stall) begin
      dr_icode <= bus.f_icode;
      dr_ifun  <= bus.f_ifun;
      dr_ra    <= bus.f_rA;
      dr_rb    <= bus.f_rB;
      dr_stat  <= bus.f_stat;
      dr_valc  <= bus.f_valC;
      dr_valp  <= bus.f_valP;
    end
  end

  assign dec = decode_regs(dr_icode, dr_ra, dr_rb);

  y86_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (dec.src_a),
    .rd_b_addr (dec.src_b),
    .rd_a_data (rf_a),
    .rd_b_data (rf_b),
    .wr_e_addr (bus.W_dstE),
    .wr_e_data (bus.W_valE),
    .wr_m_addr (bus.W_dstM),
    .wr_m_data (bus.W_valM),
    .dbg_addr  (bus.dbg_addr),
    .dbg_data  (bus.dbg_data)
  );

  // Forwarding sources, index 0 is highest priority
  assign fw_dst[0] = bus.e_dstE;  assign fw_val[0] = bus.e_valE;
  assign fw_dst[1] = bus.M_dstM;  assign fw_val[1] = bus.m_valM;
  assign fw_dst[2] = bus.M_dstE;  assign fw_val[2] = bus.M_valE;
  assign fw_dst[3] = bus.W_dstM;  assign fw_val[3] = bus.W_valM;
  assign fw_dst[4] = bus.W_dstE;  assign fw_val[4] = bus.W_valE;

  // Walk lowest priority first so the highest-priority match is applied last
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (FWD_EN) begin
      for (int k = 4; k >= 0; k--) begin
        if (fw_dst[k] != RNONE && fw_dst[k] == dec.src_a) opnd_a = fw_val[k];
        if (fw_dst[k] != RNONE && fw_dst[k] == dec.src_b) opnd_b = fw_val[k];
      end
    end
    if (dec.src_a == RNONE) opnd_a = '0;
    if (dec.src_b == RNONE) opnd_b = '0;
  end

  // Every in-flight destination blocks a reader when forwarding is off
  assign ilk_dst[0] = bus.e_dstE;
  assign ilk_dst[1] = bus.E_dstM;
  assign ilk_dst[2] = bus.M_dstE;
  assign ilk_dst[3] = bus.M_dstM;
  assign ilk_dst[4] = bus.W_dstE;
  assign ilk_dst[5] = bus.W_dstM;

  always_comb begin
    ilk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ilk_dst[k] != RNONE &&
          ((dec.src_a != RNONE && dec.src_a == ilk_dst[k]) ||
           (dec.src_b != RNONE && dec.src_b == ilk_dst[k])))
        ilk = 1'b1;
    end
  end

  assign lu = (bus.E_icode == IMRMOVQ || bus.E_icode == IPOPQ) && bus.E_dstM != RNONE &&
              (bus.E_dstM == dec.src_a || bus.E_dstM == dec.src_b);
  assign ret_h = (dr_icode == IRET) || (bus.E_icode == IRET) || (bus.M_icode == IRET);
  assign mis   = (bus.E_icode == IJXX) && !bus.e_Cnd;
  assign dep   = FWD_EN ? lu : ilk;

  // A dependency stall keeps a ret in D rather than bubbling it
  assign d_stall  = dep;
  assign d_bubble = mis | (ret_h & ~dep);

  assign bus.F_stall  = dep | ret_h;
  assign bus.D_stall  = d_stall;
  assign bus.D_bubble = d_bubble;
  assign bus.E_bubble = mis | dep;

  assign bus.d_icode = dr_icode;
  assign bus.d_ifun  = dr_ifun;
  assign bus.d_stat  = dr_stat;
  assign bus.d_srcA  = dec.src_a;
  assign bus.d_srcB  = dec.src_b;
  assign bus.d_dstE  = dec.dst_e;
  assign bus.d_dstM  = dec.dst_m;
  assign bus.d_valC  = dr_valc;
  assign bus.d_valA  = (dr_icode == IJXX || dr_icode == ICALL) ? dr_valp : opnd_a;
  assign bus.d_valB  = opnd_b;

endmodule

// File: tb/tb_pipe_decode_unit.sv
// Scoreboard bench for pipe_decode_unit: a forwarding instance and an
// interlock-only instance see identical stimulus; expectations are queued by
// the stimulus process and checked by a monitor on the falling edge.
module tb_pipe_decode_unit;
  import y86_pkg::*;

  localparam int S_ICODE = 0,  S_IFUN = 1,  S_STAT = 2,  S_SRCA = 3,  S_SRCB = 4;
  localparam int S_DSTE  = 5,  S_DSTM = 6,  S_VALA = 7,  S_VALB = 8,  S_VALC = 9;
  localparam int S_CTRL  = 10, S_DBG  = 11;
  localparam int I_ICODE = 12, I_VALA = 13, I_VALB = 14, I_CTRL = 15, I_DBG = 16;

  // ctrl encoding: {F_stall, D_stall, D_bubble, E_bubble}
  localparam logic [63:0] C_NONE = 64'h0, C_DEP = 64'hD, C_RET = 64'hA;
  localparam logic [63:0] C_MIS = 64'h3, C_MISRET = 64'hB;

  logic clk, rst;
  int   chk_cnt, pass_cnt;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  pipe_decode_unit_if #(.XLEN(64)) bf ();
  pipe_decode_unit_if #(.XLEN(64)) bi ();

  pipe_decode_unit #(.XLEN(64), .NREG(15), .FWD_EN(1'b1)) dut_fwd (.clk(clk), .rst(rst), .bus(bf));
  pipe_decode_unit #(.XLEN(64), .NREG(15), .FWD_EN(1'b0)) dut_ilk (.clk(clk), .rst(rst), .bus(bi));

  assign bi.f_icode = bf.f_icode;  assign bi.f_ifun  = bf.f_ifun;
  assign bi.f_rA    = bf.f_rA;     assign bi.f_rB    = bf.f_rB;
  assign bi.f_stat  = bf.f_stat;   assign bi.f_valC  = bf.f_valC;
  assign bi.f_valP  = bf.f_valP;   assign bi.E_icode = bf.E_icode;
  assign bi.E_dstM  = bf.E_dstM;   assign bi.M_icode = bf.M_icode;
  assign bi.e_Cnd   = bf.e_Cnd;    assign bi.e_dstE  = bf.e_dstE;
  assign bi.M_dstE  = bf.M_dstE;   assign bi.M_dstM  = bf.M_dstM;
  assign bi.W_dstE  = bf.W_dstE;   assign bi.W_dstM  = bf.W_dstM;
  assign bi.e_valE  = bf.e_valE;   assign bi.M_valE  = bf.M_valE;
  assign bi.m_valM  = bf.m_valM;   assign bi.W_valE  = bf.W_valE;
  assign bi.W_valM  = bf.W_valM;   assign bi.dbg_addr = bf.dbg_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_ICODE: return 64'(bf.d_icode);
      S_IFUN:  return 64'(bf.d_ifun);
      S_STAT:  return 64'(bf.d_stat);
      S_SRCA:  return 64'(bf.d_srcA);
      S_SRCB:  return 64'(bf.d_srcB);
      S_DSTE:  return 64'(bf.d_dstE);
      S_DSTM:  return 64'(bf.d_dstM);
      S_VALA:  return bf.d_valA;
      S_VALB:  return bf.d_valB;
      S_VALC:  return bf.d_valC;
      S_CTRL:  return 64'({bf.F_stall, bf.D_stall, bf.D_bubble, bf.E_bubble});
      S_DBG:   return bf.dbg_data;
      I_ICODE: return 64'(bi.d_icode);
      I_VALA:  return bi.d_valA;
      I_VALB:  return bi.d_valB;
      I_CTRL:  return 64'({bi.F_stall, bi.D_stall, bi.D_bubble, bi.E_bubble});
      I_DBG:   return bi.dbg_data;
      default: return 64'hBAD;
    endcase
  endfunction

  task automatic exp_push(input string name, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, compare every queued expectation
  initial begin
    exp_t e;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.sel);
        chk_cnt++;
        if (a === e.exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                       input logic [3:0] st);
    bf.f_icode = ic; bf.f_ifun = fn; bf.f_rA = ra; bf.f_rB = rb;
    bf.f_valC = vc;  bf.f_valP = vp; bf.f_stat = st;
  endtask

  task automatic fetch_nop();
    fetch(INOP, 4'd0, RNONE, RNONE, 64'h0, 64'h0, SAOK);
  endtask

  task automatic idle_later();
    bf.E_icode = INOP; bf.E_dstM = RNONE; bf.M_icode = INOP; bf.e_Cnd = 1'b1;
    bf.e_dstE = RNONE; bf.M_dstE = RNONE; bf.M_dstM = RNONE;
    bf.W_dstE = RNONE; bf.W_dstM = RNONE;
    bf.e_valE = '0; bf.M_valE = '0; bf.m_valM = '0; bf.W_valE = '0; bf.W_valM = '0;
  endtask

  function automatic logic [63:0] exp_reg(input int i);
    case (i)
      2:       return 64'h100;
      3:       return 64'h77;
      4:       return 64'h9;
      default: return 64'h0;
    endcase
  endfunction

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rst = 1'b1;
    fetch_nop();
    idle_later();
    bf.dbg_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of the D register and controls
    exp_push("rst_icode", S_ICODE, 64'h1);
    exp_push("rst_ifun",  S_IFUN,  64'h0);
    exp_push("rst_stat",  S_STAT,  64'h1);
    exp_push("rst_srcA",  S_SRCA,  64'hF);
    exp_push("rst_srcB",  S_SRCB,  64'hF);
    exp_push("rst_dstE",  S_DSTE,  64'hF);
    exp_push("rst_dstM",  S_DSTM,  64'hF);
    exp_push("rst_valA",  S_VALA,  64'h0);
    exp_push("rst_valB",  S_VALB,  64'h0);
    exp_push("rst_valC",  S_VALC,  64'h0);
    exp_push("rst_ctrl",  S_CTRL,  C_NONE);
    exp_push("rst_ilk_ctrl", I_CTRL, C_NONE);

    for (int i = 0; i < 16; i++) begin
      step();
      bf.dbg_addr = 4'(i);
      exp_push($sformatf("rst_reg%0d", i), S_DBG, 64'h0);
    end

    // Dual write to reg 4: M wins, visible from the next cycle
    step();
    bf.W_dstE = 4'd4; bf.W_valE = 64'd5; bf.W_dstM = 4'd4; bf.W_valM = 64'd9;
    bf.dbg_addr = 4'd4;
    exp_push("wr_not_yet", S_DBG, 64'h0);
    step();
    bf.W_dstE = 4'd2; bf.W_valE = 64'h100; bf.W_dstM = 4'd3; bf.W_valM = 64'h300;
    exp_push("wr_m_wins", S_DBG, 64'h9);
    step();
    idle_later();
    bf.dbg_addr = 4'd2;
    exp_push("wr_r2", S_DBG, 64'h100);
    step();
    bf.dbg_addr = 4'd3;
    exp_push("wr_r3", S_DBG, 64'h300);

    // OPq forwarding priorities vs interlock stall
    step();
    fetch(IOPQ, 4'd0, 4'd2, 4'd3, 64'h0, 64'h2A, SAOK);
    step();
    fetch_nop();
    bf.e_dstE = 4'd2; bf.e_valE = 64'h11;
    bf.M_dstE = 4'd2; bf.M_valE = 64'h22;
    bf.W_dstM = 4'd3; bf.W_valM = 64'h77;
    bf.W_dstE = 4'd3; bf.W_valE = 64'h66;
    exp_push("op_icode", S_ICODE, 64'h6);
    exp_push("op_srcA",  S_SRCA,  64'h2);
    exp_push("op_srcB",  S_SRCB,  64'h3);
    exp_push("op_dstE",  S_DSTE,  64'h3);
    exp_push("op_dstM",  S_DSTM,  64'hF);
    exp_push("fwd_e_prio", S_VALA, 64'h11);
    exp_push("fwd_wm_prio", S_VALB, 64'h77);
    exp_push("op_ctrl", S_CTRL, C_NONE);
    exp_push("ilk_ctrl", I_CTRL, C_DEP);
    exp_push("ilk_valA_rf", I_VALA, 64'h100);
    exp_push("ilk_valB_rf", I_VALB, 64'h300);
    step();
    idle_later();
    exp_push("op_next_icode", S_ICODE, 64'h1);
    exp_push("ilk_hold_icode", I_ICODE, 64'h6);
    exp_push("ilk_release_ctrl", I_CTRL, C_NONE);
    exp_push("ilk_valB_new", I_VALB, 64'h77);
    step();
    exp_push("ilk_next_icode", I_ICODE, 64'h1);

    // Load-use hazard
    step();
    fetch(IOPQ, 4'd0, 4'd2, 4'd3, 64'h0, 64'h2C, SAOK);
    step();
    fetch_nop();
    bf.E_icode = IMRMOVQ; bf.E_dstM = 4'd3;
    exp_push("lu_ctrl", S_CTRL, C_DEP);
    exp_push("lu_ilk_ctrl", I_CTRL, C_DEP);
    step();
    bf.E_icode = INOP; bf.E_dstM = RNONE;
    bf.M_icode = IMRMOVQ; bf.M_dstM = 4'd3; bf.m_valM = 64'h55;
    bf.M_dstE = 4'd3; bf.M_valE = 64'h99;
    exp_push("lu_hold_icode", S_ICODE, 64'h6);
    exp_push("lu_release_ctrl", S_CTRL, C_NONE);
    exp_push("fwd_mm_over_me", S_VALB, 64'h55);
    exp_push("lu_ilk_m_ctrl", I_CTRL, C_DEP);
    step();
    idle_later();
    exp_push("lu_next_icode", S_ICODE, 64'h1);
    exp_push("lu_ilk_hold", I_ICODE, 64'h6);
    exp_push("lu_ilk_ctrl0", I_CTRL, C_NONE);
    step();
    exp_push("lu_ilk_next", I_ICODE, 64'h1);

    // ret moving D -> E -> M
    step();
    fetch(IRET, 4'd0, RNONE, RNONE, 64'h0, 64'h30, SAOK);
    step();
    fetch_nop();
    exp_push("ret_icode", S_ICODE, 64'h9);
    exp_push("ret_srcA",  S_SRCA,  64'h4);
    exp_push("ret_dstE",  S_DSTE,  64'h4);
    exp_push("ret_valA",  S_VALA,  64'h9);
    exp_push("ret_valB",  S_VALB,  64'h9);
    exp_push("ret_d_ctrl", S_CTRL, C_RET);
    exp_push("ret_d_ilk_ctrl", I_CTRL, C_RET);
    step();
    bf.E_icode = IRET;
    exp_push("ret_e_icode", S_ICODE, 64'h1);
    exp_push("ret_e_ctrl", S_CTRL, C_RET);
    step();
    bf.E_icode = INOP; bf.M_icode = IRET;
    exp_push("ret_m_ctrl", S_CTRL, C_RET);
    step();
    bf.M_icode = INOP;
    fetch(IIRMOVQ, 4'd0, RNONE, 4'd5, 64'h1234, 64'h3A, SAOK);
    exp_push("ret_done_ctrl", S_CTRL, C_NONE);
    step();
    fetch_nop();
    exp_push("irmov_icode", S_ICODE, 64'h3);
    exp_push("irmov_dstE",  S_DSTE,  64'h5);
    exp_push("irmov_srcA",  S_SRCA,  64'hF);
    exp_push("irmov_valC",  S_VALC,  64'h1234);
    exp_push("irmov_valA",  S_VALA,  64'h0);
    exp_push("irmov_ctrl",  S_CTRL,  C_NONE);

    // Mispredicted branch squashes the instruction in D
    step();
    fetch(IJXX, 4'd1, RNONE, RNONE, 64'h40, 64'h20, SAOK);
    step();
    fetch(IOPQ, 4'd0, 4'd2, 4'd3, 64'h0, 64'h22, SAOK);
    exp_push("jxx_valA_valP", S_VALA, 64'h20);
    exp_push("jxx_valC", S_VALC, 64'h40);
    exp_push("jxx_ctrl", S_CTRL, C_NONE);
    step();
    fetch(IRRMOVQ, 4'd0, 4'd1, 4'd2, 64'h0, 64'h24, SADR);
    bf.E_icode = IJXX; bf.e_Cnd = 1'b0;
    exp_push("mis_icode", S_ICODE, 64'h6);
    exp_push("mis_ctrl", S_CTRL, C_MIS);
    exp_push("mis_ilk_ctrl", I_CTRL, C_MIS);
    step();
    fetch_nop();
    idle_later();
    exp_push("mis_next_icode", S_ICODE, 64'h1);
    exp_push("mis_next_ifun",  S_IFUN,  64'h0);
    exp_push("mis_next_stat",  S_STAT,  64'h1);
    exp_push("mis_next_ctrl",  S_CTRL,  C_NONE);

    // Mispredict with ret in D: ret squashed
    step();
    fetch(IRET, 4'd0, RNONE, RNONE, 64'h0, 64'h31, SAOK);
    step();
    fetch_nop();
    bf.E_icode = IJXX; bf.e_Cnd = 1'b0;
    exp_push("misret_ctrl", S_CTRL, C_MISRET);
    step();
    idle_later();
    exp_push("misret_icode", S_ICODE, 64'h1);
    exp_push("misret_next_ctrl", S_CTRL, C_NONE);

    // Load-use with ret in D: ret held, not bubbled
    step();
    fetch(IRET, 4'd0, RNONE, RNONE, 64'h0, 64'h32, SAOK);
    step();
    fetch_nop();
    bf.E_icode = IPOPQ; bf.E_dstM = 4'd4;
    exp_push("depret_ctrl", S_CTRL, C_DEP);
    exp_push("depret_ilk_ctrl", I_CTRL, C_DEP);
    step();
    idle_later();
    exp_push("depret_hold", S_ICODE, 64'h9);
    exp_push("depret_ret_ctrl", S_CTRL, C_RET);
    step();
    exp_push("depret_flush", S_ICODE, 64'h1);
    exp_push("depret_done_ctrl", S_CTRL, C_NONE);

    // Writes to RNONE change nothing
    step();
    bf.W_dstE = RNONE; bf.W_valE = 64'hDEAD; bf.W_dstM = RNONE; bf.W_valM = 64'hBEEF;
    step();
    idle_later();
    for (int i = 0; i < 16; i++) begin
      step();
      bf.dbg_addr = 4'(i);
      exp_push($sformatf("keep_reg%0d", i), S_DBG, exp_reg(i));
      exp_push($sformatf("keep_ilk_reg%0d", i), I_DBG, exp_reg(i));
    end

    // Reset during a load-use stall
    step();
    fetch(IOPQ, 4'd0, 4'd2, 4'd3, 64'h0, 64'h40, SAOK);
    step();
    fetch_nop();
    bf.E_icode = IMRMOVQ; bf.E_dstM = 4'd3;
    rst = 1'b1;
    exp_push("rststall_ctrl", S_CTRL, C_DEP);
    step();
    rst = 1'b0;
    idle_later();
    bf.dbg_addr = 4'd4;
    exp_push("rststall_icode", S_ICODE, 64'h1);
    exp_push("rststall_ctrl0", S_CTRL, C_NONE);
    exp_push("rststall_r4", S_DBG, 64'h0);
    exp_push("rststall_ilk_r4", I_DBG, 64'h0);
    step();
    bf.dbg_addr = 4'd3;
    exp_push("rststall_r3", S_DBG, 64'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
